min_frame_loader: RTL
=====================

MIN_FRAME_LOADER -- requirements
Module: min_frame_loader

Interface
REQ-001 SHALL have parameter: W, 4, sample width in bits; fixed at 4, no other value supported.
REQ-002 SHALL have parameter: N, 16, samples per frame; fixed at 16, no other value supported.
REQ-003 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: in_valid  input  1  in_data carries a sample this cycle.
REQ-006 SHALL have port: in_ready  output  1  loader accepts a sample this cycle.
REQ-007 SHALL have port: in_data  input  4  unsigned sample.
REQ-008 SHALL have port: in_sof  input  1  start of frame, qualified by in_valid.
REQ-009 SHALL have port: flush  input  1  close the partial frame now.
REQ-010 SHALL have port: frame_valid  output  1  frame_data holds a complete frame.
REQ-011 SHALL have port: frame_ack  input  1  consumer has taken the frame.
REQ-012 SHALL have port: frame_data  output  64  slot k on bits [4k+3:4k]; drives I0..I15 of min_finder_1/min_finder_2.
REQ-013 SHALL have port: fill_cnt  output  4  number of slots written in the current fill.
REQ-014 SHALL have port: resync_err  output  1  one-cycle pulse when a partial frame is discarded.
REQ-015 SHALL have port: frame_cnt  output  8  count of completed frames; wraps 255->0.

Function
REQ-016 SHALL implement two states: FILL (in_ready=1, frame_valid=0) and HOLD (in_ready=0, frame_valid=1).
REQ-017 SHALL, in FILL on handshake (in_valid & in_ready), write in_data to slot fill_cnt and increment fill_cnt.
REQ-018 SHALL, on the handshake writing slot 15, go to HOLD next cycle, set fill_cnt=0 and increment frame_cnt.
REQ-019 SHALL, on a handshake with in_sof=1 and fill_cnt!=0, discard the partial frame, write the sample to slot 0, set fill_cnt=1 and pulse resync_err for exactly one cycle.
REQ-020 SHALL, on a handshake with in_sof=1 and fill_cnt=0, write slot 0 normally with no resync_err.
REQ-021 SHALL, when flush=1 in FILL with fill_cnt!=0 or a same-cycle handshake, write any same-cycle sample first, fill all remaining slots with 4'hF, and go to HOLD next cycle with frame_cnt incremented.
REQ-022 SHALL ignore flush in FILL when fill_cnt=0 and no handshake occurs that cycle; no empty frames are produced.
REQ-023 SHALL ignore flush in HOLD.
REQ-024 SHALL hold frame_data stable throughout HOLD.
REQ-025 SHALL, on frame_ack in HOLD, return to FILL next cycle.
REQ-026 SHALL ignore in_valid in the frame_ack cycle because in_ready=0 in HOLD; the first new sample is accepted one cycle later.
REQ-027 SHALL ignore frame_ack in FILL.
REQ-028 SHALL, in FILL, overwrite frame_data slots in place; frame_data is valid only while frame_valid=1.
REQ-029 SHALL make all outputs registered, except in_ready, which decodes directly from state.
REQ-030 SHALL leave frame_data unaffected by resync_err except for the slot-0 write described in REQ-019.

Reset
REQ-031 SHALL, on rst_n low, immediately set state=FILL, fill_cnt=0, frame_cnt=0, resync_err=0, frame_valid=0 and every frame_data slot=4'hF.
REQ-032 SHALL, on reset mid-fill or in HOLD, abandon the frame and take no further action on it.
REQ-033 SHALL accept a handshake on the first rising clk edge after rst_n deasserts.

Verification
REQ-034 SHALL cover: 16 back-to-back samples 2,3,1,2,5,6,9,9,9,9,9,9,9,9,9,9 -> frame_valid high the cycle after the 16th handshake, frame_data[3:0]=2, [11:8]=1, frame_cnt=1, min_finder outputs min1=1, index_min1=2.
REQ-035 SHALL cover: samples 5,2,10,0,4,1 then flush -> HOLD next cycle, slots 6..15=4'hF, min1=0, min2=1, index_min1=3.
REQ-036 SHALL cover: 7 samples then an in_sof sample of value 3 -> resync_err pulses one cycle, fill_cnt=1, slot 0=3, frame_cnt unchanged.
REQ-037 SHALL cover: in HOLD, in_valid held high with frame_ack for one cycle -> that sample is not accepted, in_ready=1 the next cycle, the following sample lands in slot 0.
REQ-038 SHALL cover: flush with fill_cnt=0 and no in_valid -> no state change; flush in HOLD -> frame_data unchanged.
REQ-039 SHALL cover: rst_n pulsed low mid-fill at fill_cnt=9 -> outputs reach their reset values asynchronously, with no clock edge needed, and frame_cnt=0; 256 frames after reset -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/min_frame_loader.sv
// Collects 16 four-bit samples into a frame for the min finders, with SOF
// resync, flush padding (4'hF) and a FILL/HOLD handshake with the consumer.
module mfl_slot #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic         pad,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '1;
    else if (we)  q <= d;
    else if (pad) q <= '1;
  end
endmodule

module min_frame_loader #(
  parameter int W = 4,
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [W-1:0]         in_data,
  input  logic                 in_sof,
  input  logic                 flush,
  output logic                 frame_valid,
  input  logic                 frame_ack,
  output logic [N*W-1:0]       frame_data,
  output logic [$clog2(N)-1:0] fill_cnt,
  output logic                 resync_err,
  output logic [7:0]           frame_cnt
);
  localparam int CW = $clog2(N);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       fill_cnt_nx;
  logic [7:0]          frame_cnt_nx;
  logic                resync_nx;
  logic                hs;
  logic [CW-1:0]       wr_idx;
  logic [CW:0]         pad_from;
  logic                pad_en;
  logic [N-1:0]        we, pad;
  logic [N-1:0][W-1:0] slots;

  assign in_ready = (state == FILL);
  assign hs       = in_valid & in_ready;
  // An SOF sample always restarts the frame at slot 0.
  assign wr_idx   = in_sof ? '0 : fill_cnt;

  always_comb begin
    state_nx     = state;
    fill_cnt_nx  = fill_cnt;
    frame_cnt_nx = frame_cnt;
    resync_nx    = 1'b0;
    pad_en       = 1'b0;
    pad_from     = {1'b0, fill_cnt};
    case (state)
      FILL: begin
        if (hs) begin
          resync_nx   = in_sof && (fill_cnt != '0);
          fill_cnt_nx = wr_idx + 1'b1;
          pad_from    = {1'b0, wr_idx} + 1'b1;
          if (wr_idx == CW'(N-1) || flush) begin
            pad_en       = flush;
            state_nx     = HOLD;
            fill_cnt_nx  = '0;
            frame_cnt_nx = frame_cnt + 8'd1;
          end
        end else if (flush && fill_cnt != '0) begin
          pad_en       = 1'b1;
          state_nx     = HOLD;
          fill_cnt_nx  = '0;
          frame_cnt_nx = frame_cnt + 8'd1;
        end
      end
      HOLD: if (frame_ack) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      fill_cnt    <= '0;
      frame_cnt   <= '0;
      resync_err  <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_nx;
      fill_cnt    <= fill_cnt_nx;
      frame_cnt   <= frame_cnt_nx;
      resync_err  <= resync_nx;
      frame_valid <= (state_nx == HOLD);
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    assign we[k]  = hs && (wr_idx == CW'(k));
    assign pad[k] = pad_en && ((CW+1)'(k) >= pad_from);
    mfl_slot #(.W(W)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[k]),
      .pad   (pad[k]),
      .d     (in_data),
      .q     (slots[k])
    );
  end

  assign frame_data = slots;
endmodule
